// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the digit-serial adder/subtractor.
//   - state_t    : control FSM encoding (IDLE / RUN / DONE)
//   - cnt_width  : width of the digit counter, never less than one bit
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-digit operation still needs a one-bit counter to keep the
  // datapath code uniform.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
//   Combinational DIGIT_W-bit ripple-carry adder built from full-adder cells.
//   Ports:
//     x, y      in  DIGIT_W  addend digits
//     ci        in  1        carry into bit 0
//     s         out DIGIT_W  digit sum
//     co        out 1        carry out of the top bit
//     c_msb_in  out 1        carry into the top bit (for signed overflow)
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               c_msb_in
);

  // c[i] is the carry into bit i; c[DIGIT_W] is the carry out.
  logic [DIGIT_W:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
      logic p;
      assign p         = x[gi] ^ y[gi];
      assign s[gi]     = p ^ c[gi];
      assign c[gi + 1] = (x[gi] & y[gi]) | (p & c[gi]);
    end
  endgenerate

  assign co       = c[DIGIT_W];
  assign c_msb_in = c[DIGIT_W-1];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operation is processed as
//   NDIG = WIDTH/DIGIT_W digits, least significant first, one digit per clock.
//   The carry is held in a register between digits.
//
//   Parameters:
//     WIDTH    operand/result width (must be a multiple of DIGIT_W)
//     DIGIT_W  bits added per clock
//
//   Ports:
//     clk, rst_n           clock (rising edge), asynchronous active-low reset
//     in_valid / in_ready  operand handshake; accept only in IDLE
//     a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//     out_valid/out_ready  result handshake; result held until taken
//     sum, cout            result and carry out of the MSB (1 = no borrow)
//     busy                 high while an operation is running or held
//     ovf                  signed overflow, only when SERIAL_ADDER_OVF_EN is
//                          defined
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0]   opa_reg, opb_reg, sum_reg;
  logic               carry_reg, cout_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               accept, last_dig;
  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_co, dig_c_msb;

  // Digit views of the latched operands, selected by the digit counter.
  logic [DIGIT_W-1:0] a_dig [NDIG];
  logic [DIGIT_W-1:0] b_dig [NDIG];

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi] = opa_reg[gi*DIGIT_W +: DIGIT_W];
      assign b_dig[gi] = opb_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign dig_a    = a_dig[cnt_reg];
  assign dig_b    = b_dig[cnt_reg];
  assign accept   = in_valid & in_ready;
  assign last_dig = (cnt_reg == LAST_DIG);

  digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_adder (
    .x        (dig_a),
    .y        (dig_b),
    .ci       (carry_reg),
    .s        (dig_s),
    .co       (dig_co),
    .c_msb_in (dig_c_msb)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_dig)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the current state only, so a result and the
  // next accept can never coincide.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. Subtraction is a + ~b + 1: b is inverted on capture and the
  // "+1" enters as the initial carry, so the digit loop is identical for both.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      opa_reg   <= a;
      opb_reg   <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      carry_reg <= dig_co;
      cnt_reg   <= cnt_reg + 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (cnt_reg == CNT_W'(i)) begin
          sum_reg[i*DIGIT_W +: DIGIT_W] <= dig_s;
        end
      end
      if (last_dig) begin
        cout_reg <= dig_co;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // Two's-complement overflow: carry into the MSB differs from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if ((state_reg == RUN) && last_dig) begin
      ovf_reg <= dig_c_msb ^ dig_co;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_c_msb;
  assign unused_c_msb = dig_c_msb;
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int WIDTH   = 8;
  localparam int DIGIT_W = 4;
  localparam int NDIG    = WIDTH / DIGIT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  serial_adder #(
    .WIDTH   (WIDTH),
    .DIGIT_W (DIGIT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  int   ready_mode = 0;   // 0: random, 1: held low, 2: held high
  int   n_results  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_v,
                                 input logic tcin, input logic tsub);
    exp_t e;
    int ua, ub, r, sa, sb, sr;
    ua = int'(ta);
    ub = int'(tb_v);
    sa = int'($signed(ta));
    sb = int'($signed(tb_v));
    if (tsub) begin
      r   = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      r   = ua + ub + int'(tcin);
      sr  = sa + sb + int'(tcin);
      e.c = (r > 255);
    end
    e.s = 8'(r & 255);
    e.v = (sr > 127) || (sr < -128);
    return e;
  endfunction

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = ($urandom % 3) != 0;
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       pv;
    logic [7:0] ps;
    logic       pc;
    exp_t       e;
    int         acc;
    pv = 1'b0;
    ps = '0;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (out_valid) begin
          check("in_ready_in_done", in_ready, 0);
          check("busy_in_done", busy, 1);
          if (!pv) begin
            if (acc_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result: out_valid with no accepted operation, sum=%h", sum);
            end else begin
              acc = acc_q.pop_front();
              check("latency", cyc - acc, NDIG);
            end
          end else begin
            check("sum_stable", sum, ps);
            check("cout_stable", cout, pc);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL result_no_expect: got sum=%h, expected none", sum);
            end else begin
              e = exp_q.pop_front();
              n_results++;
              check("sum", sum, e.s);
              check("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
              check("ovf", ovf, e.v);
`endif
              $display("result %0d: sum=%h cout=%b (exp sum=%h cout=%b ovf=%b)",
                       n_results, sum, cout, e.s, e.c, e.v);
            end
          end
        end
        pv = out_valid && !out_ready;
        ps = sum;
        pc = cout;
      end
    end
  end

  // Issue one operation; noise on in_valid while the block is busy.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tcin, input logic tsub);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      in_valid = 1'($urandom % 2);
      a        = 8'($urandom);
      b        = 8'($urandom);
      cin      = 1'($urandom);
      sub      = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
    end else begin
      in_valid = 1'b1;
      a        = ta;
      b        = tb_v;
      cin      = tcin;
      sub      = tsub;
      exp_q.push_back(model(ta, tb_v, tcin, tsub));
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      cin      = 1'($urandom);
      sub      = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, 0);
`endif
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases
    issue(8'h3C, 8'h05, 1'b0, 1'b0);
    issue(8'h0F, 8'h00, 1'b1, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    issue(8'h07, 8'h05, 1'b0, 1'b1);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    drain();

    // Result held in DONE while new operands are offered
    ready_mode = 1;
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 8'($urandom);
      b        = 8'($urandom);
      sub      = 1'($urandom);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid   = 1'b0;
    check("hold_sum", sum, 8'h46);
    ready_mode = 2;
    @(negedge clk);
    check("release_out_ready", out_ready, 1);
    @(negedge clk);
    check("release_idle_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_pending", exp_q.size(), 0);
    ready_mode = 0;

    // Reset after the first RUN cycle aborts the operation
    issue(8'hAA, 8'h11, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_abort");
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
    check("results_seen", n_results, 159);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
